// File: rtl/lcd1602_pkg.sv
// Shared definitions for the LCD1602 refresh controller: FSM states,
// HD44780 init commands, line start addresses and frame geometry.
package lcd1602_pkg;

  typedef enum logic [2:0] {
    ST_PWRUP,
    ST_INIT_ISSUE,
    ST_INIT_WAIT,
    ST_CLR_DLY,
    ST_IDLE,
    ST_REF_ISSUE,
    ST_REF_WAIT
  } state_t;

  // Init commands: 8-bit bus/2 lines/5x8, display on, clear, entry increment
  localparam logic [7:0] CMD_FUNC_SET = 8'h38;
  localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
  localparam logic [7:0] CMD_CLEAR    = 8'h01;
  localparam logic [7:0] CMD_ENTRY    = 8'h06;

  // Set-DDRAM-address commands for the start of each line
  localparam logic [7:0] LINE1_ADDR = 8'h80;
  localparam logic [7:0] LINE2_ADDR = 8'hC0;

  localparam logic [7:0] BLANK_CHAR = 8'h20;

  // Frame: step 0 = line-1 address, 1-16 chars, 17 = line-2 address, 18-33 chars
  localparam logic [5:0] FRAME_LAST = 6'd33;
  localparam logic [5:0] LINE2_STEP = 6'd17;

  // Init step 2 is the clear command, which needs the extra settle delay
  localparam logic [1:0] INIT_LAST  = 2'd3;
  localparam logic [1:0] CLEAR_STEP = 2'd2;

  function automatic logic [7:0] initRom(input logic [1:0] step);
    logic [7:0] cmd;
    case (step)
      2'd0:    cmd = CMD_FUNC_SET;
      2'd1:    cmd = CMD_DISP_ON;
      2'd2:    cmd = CMD_CLEAR;
      default: cmd = CMD_ENTRY;
    endcase
    return cmd;
  endfunction

endpackage

// File: rtl/lcd1602_char_buf.sv
// 32x8 character buffer mirroring the two LCD lines. One synchronous
// write port for the host, one asynchronous read port for the refresh FSM.
// A read of the address being written returns the old contents.
module lcd1602_char_buf
  import lcd1602_pkg::*;
(
  input  logic       Clk,
  input  logic       Rst,
  input  logic       i_we,
  input  logic [4:0] i_waddr,
  input  logic [7:0] i_wdata,
  input  logic [4:0] i_raddr,
  output logic [7:0] o_rdata
);

  logic [7:0] r_mem [32];

  // Storage: every cell clears to a space on reset, host writes land on the clock edge
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      for (int i = 0; i < 32; i++) begin
        r_mem[i] <= BLANK_CHAR;
      end
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/lcd1602_ctrl.sv
// LCD1602 controller: waits out the power-up time, runs the four-command
// init sequence, then streams the character buffer to the LCD driver as
// frames of 34 writes while refresh_en is high. Each write is a one-cycle
// wr_cmd/wr_data pulse followed by a wait for the driver's wr_done.
module lcd1602_ctrl
  import lcd1602_pkg::*;
#(
  parameter int PWRUP_CYC = 750000,
  parameter int CLR_CYC   = 100000
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       buf_we,
  input  logic [4:0] buf_addr,
  input  logic [7:0] buf_wdata,
  input  logic       refresh_en,
  output logic       init_done,
  output logic       busy,
  output logic       wr_cmd,
  output logic       wr_data,
  output logic [7:0] data,
  input  logic       wr_done
);

  localparam logic [31:0] PWRUP_LAST = 32'(PWRUP_CYC - 1);
  localparam logic [31:0] CLR_LAST   = 32'(CLR_CYC - 1);

  state_t      r_state;
  logic [31:0] r_cnt;
  logic [1:0]  r_initStep;
  logic [5:0]  r_frameStep;
  logic        r_initDone;
  logic        r_wrCmd;
  logic        r_wrData;
  logic [7:0]  r_data;

  state_t      w_nextState;
  logic [31:0] w_nextCnt;
  logic [1:0]  w_nextInitStep;
  logic [5:0]  w_nextFrameStep;
  logic        w_nextInitDone;
  logic        w_nextWrCmd;
  logic        w_nextWrData;
  logic [7:0]  w_nextData;

  logic [4:0]  w_rdAddr;
  logic [7:0]  w_rdData;

  // Line-1 chars sit at steps 1-16, line-2 chars at steps 18-33
  assign w_rdAddr = (r_frameStep < LINE2_STEP) ? 5'(r_frameStep - 6'd1)
                                               : 5'(r_frameStep - 6'd2);

  lcd1602_char_buf u_charBuf (
    .Clk     (Clk),
    .Rst     (Rst),
    .i_we    (buf_we),
    .i_waddr (buf_addr),
    .i_wdata (buf_wdata),
    .i_raddr (w_rdAddr),
    .o_rdata (w_rdData)
  );

  // Next-state logic: sequencing, counters, and the registered write pulse/data
  always_comb begin
    w_nextState     = r_state;
    w_nextCnt       = r_cnt;
    w_nextInitStep  = r_initStep;
    w_nextFrameStep = r_frameStep;
    w_nextInitDone  = r_initDone;
    w_nextWrCmd     = 1'b0;
    w_nextWrData    = 1'b0;
    w_nextData      = r_data;

    case (r_state)
      ST_PWRUP: begin
        if (r_cnt == PWRUP_LAST) begin
          w_nextCnt      = '0;
          w_nextInitStep = '0;
          w_nextState    = ST_INIT_ISSUE;
        end else begin
          w_nextCnt = r_cnt + 32'd1;
        end
      end

      ST_INIT_ISSUE: begin
        w_nextData  = initRom(r_initStep);
        w_nextWrCmd = 1'b1;
        w_nextState = ST_INIT_WAIT;
      end

      ST_INIT_WAIT: begin
        if (wr_done) begin
          if (r_initStep == CLEAR_STEP) begin
            w_nextCnt   = '0;
            w_nextState = ST_CLR_DLY;
          end else if (r_initStep == INIT_LAST) begin
            w_nextInitDone = 1'b1;
            w_nextState    = ST_IDLE;
          end else begin
            w_nextInitStep = r_initStep + 2'd1;
            w_nextState    = ST_INIT_ISSUE;
          end
        end
      end

      ST_CLR_DLY: begin
        if (r_cnt == CLR_LAST) begin
          w_nextCnt      = '0;
          w_nextInitStep = r_initStep + 2'd1;
          w_nextState    = ST_INIT_ISSUE;
        end else begin
          w_nextCnt = r_cnt + 32'd1;
        end
      end

      ST_IDLE: begin
        if (refresh_en) begin
          w_nextFrameStep = '0;
          w_nextState     = ST_REF_ISSUE;
        end
      end

      ST_REF_ISSUE: begin
        if (r_frameStep == 6'd0) begin
          w_nextData  = LINE1_ADDR;
          w_nextWrCmd = 1'b1;
        end else if (r_frameStep == LINE2_STEP) begin
          w_nextData  = LINE2_ADDR;
          w_nextWrCmd = 1'b1;
        end else begin
          w_nextData   = w_rdData;
          w_nextWrData = 1'b1;
        end
        w_nextState = ST_REF_WAIT;
      end

      ST_REF_WAIT: begin
        if (wr_done) begin
          if (r_frameStep != FRAME_LAST) begin
            w_nextFrameStep = r_frameStep + 6'd1;
            w_nextState     = ST_REF_ISSUE;
          end else if (refresh_en) begin
            w_nextFrameStep = '0;
            w_nextState     = ST_REF_ISSUE;
          end else begin
            w_nextFrameStep = '0;
            w_nextState     = ST_IDLE;
          end
        end
      end

      default: begin
        w_nextState = ST_PWRUP;
      end
    endcase
  end

  // State and output registers; reset abandons any outstanding write
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_state     <= ST_PWRUP;
      r_cnt       <= '0;
      r_initStep  <= '0;
      r_frameStep <= '0;
      r_initDone  <= 1'b0;
      r_wrCmd     <= 1'b0;
      r_wrData    <= 1'b0;
      r_data      <= 8'h00;
    end else begin
      r_state     <= w_nextState;
      r_cnt       <= w_nextCnt;
      r_initStep  <= w_nextInitStep;
      r_frameStep <= w_nextFrameStep;
      r_initDone  <= w_nextInitDone;
      r_wrCmd     <= w_nextWrCmd;
      r_wrData    <= w_nextWrData;
      r_data      <= w_nextData;
    end
  end

  assign init_done = r_initDone;
  assign busy      = (r_state != ST_IDLE);
  assign wr_cmd    = r_wrCmd;
  assign wr_data   = r_wrData;
  assign data      = r_data;

endmodule

// File: tb/tb_lcd1602_ctrl.sv
// Testbench for lcd1602_ctrl: a driver model answers every write pulse with
// wr_done a fixed number of cycles later and logs each transfer; expected
// init and frame sequences come from tables built from a local buffer model.
module tb_lcd1602_ctrl;

  localparam int PWRUP_CYC = 20;
  localparam int CLR_CYC   = 10;
  localparam int DONE_LAT  = 5;
  localparam int FRAME_LEN = 34;

  typedef struct { logic isCmd; logic [7:0] data; } vec_t;
  typedef struct { logic isCmd; logic [7:0] data; int cyc; } xfer_t;

  logic       Clk;
  logic       Rst;
  logic       buf_we;
  logic [4:0] buf_addr;
  logic [7:0] buf_wdata;
  logic       refresh_en;
  logic       init_done;
  logic       busy;
  logic       wr_cmd;
  logic       wr_data;
  logic [7:0] data;
  logic       wr_done;

  logic       modelDone;
  logic       spuriousDone;

  int         nVec = 0;
  int         nMiss = 0;
  int         protoErr = 0;
  int         cyc = 0;
  int         relCyc = 0;
  int         doneCnt = -1;
  logic       outstanding = 1'b0;
  logic [7:0] heldData = 8'h00;

  xfer_t      logQ[$];
  int         doneCycQ[$];
  logic [7:0] bufModel [32];
  vec_t       frameExp [FRAME_LEN];
  vec_t       initExp [4];

  assign wr_done = modelDone | spuriousDone;

  lcd1602_ctrl #(
    .PWRUP_CYC (PWRUP_CYC),
    .CLR_CYC   (CLR_CYC)
  ) dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .buf_we     (buf_we),
    .buf_addr   (buf_addr),
    .buf_wdata  (buf_wdata),
    .refresh_en (refresh_en),
    .init_done  (init_done),
    .busy       (busy),
    .wr_cmd     (wr_cmd),
    .wr_data    (wr_data),
    .data       (data),
    .wr_done    (wr_done)
  );

  // 100 MHz-style free-running clock
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Cycle counter used to timestamp transfers
  always @(posedge Clk) cyc++;

  // Driver model and monitor: log pulses, check protocol, return wr_done
  always @(negedge Clk) begin
    if (Rst) begin
      doneCnt     = -1;
      modelDone   = 1'b0;
      outstanding = 1'b0;
    end else begin
      if (modelDone) begin
        modelDone   = 1'b0;
        outstanding = 1'b0;
      end
      if (wr_cmd && wr_data) begin
        protoErr++;
        $display("[TB] protocol violation: wr_cmd and wr_data together at cycle %0d", cyc);
      end
      if (wr_cmd || wr_data) begin
        if (outstanding) begin
          protoErr++;
          $display("[TB] protocol violation: pulse while write outstanding at cycle %0d", cyc);
        end
        outstanding = 1'b1;
        heldData    = data;
        logQ.push_back('{wr_cmd, data, cyc});
        doneCnt     = DONE_LAT;
      end else begin
        if (outstanding && data !== heldData) begin
          protoErr++;
          $display("[TB] protocol violation: data changed while outstanding at cycle %0d", cyc);
        end
        if (doneCnt > 0) begin
          doneCnt--;
          if (doneCnt == 0) begin
            modelDone = 1'b1;
            doneCnt   = -1;
            doneCycQ.push_back(cyc);
          end
        end
      end
    end
  end

  // Global watchdog so the bench can never hang
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nVec++;
    if (actual !== expected) begin
      nMiss++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [4:0] addr, input logic [7:0] wdata);
    @(negedge Clk);
    buf_we         = 1'b1;
    buf_addr       = addr;
    buf_wdata      = wdata;
    bufModel[addr] = wdata;
    @(negedge Clk);
    buf_we         = 1'b0;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge Clk);
    #1;
  endtask

  task automatic waitXfers(input int n, input int budget);
    int t;
    t = 0;
    while (logQ.size() < n && t < budget) begin
      @(negedge Clk);
      #1;
      t++;
    end
    checkOutput($sformatf("xfer_count_%0d", n), 32'(logQ.size() >= n), 32'd1);
  endtask

  task automatic buildFrame();
    frameExp[0]  = '{1'b1, 8'h80};
    frameExp[17] = '{1'b1, 8'hC0};
    for (int i = 0; i < 16; i++) begin
      frameExp[1 + i]  = '{1'b0, bufModel[i]};
      frameExp[18 + i] = '{1'b0, bufModel[16 + i]};
    end
  endtask

  task automatic compareFrame(input int base, input string tag);
    for (int i = 0; i < FRAME_LEN; i++) begin
      if (base + i < logQ.size()) begin
        checkOutput($sformatf("%s[%0d]", tag, i),
                    {23'b0, logQ[base + i].isCmd, logQ[base + i].data},
                    {23'b0, frameExp[i].isCmd, frameExp[i].data});
      end else begin
        checkOutput($sformatf("%s[%0d]_present", tag, i), 32'd0, 32'd1);
      end
    end
  endtask

  task automatic pulseRefresh();
    @(negedge Clk);
    refresh_en = 1'b1;
    @(negedge Clk);
    refresh_en = 1'b0;
  endtask

  task automatic runInit(input string tag);
    waitXfers(4, 400);
    if (logQ.size() >= 4 && doneCycQ.size() >= 3) begin
      checkOutput({tag, "_pwrup_wait"}, 32'(logQ[0].cyc - relCyc > PWRUP_CYC), 32'd1);
      for (int i = 0; i < 4; i++) begin
        checkOutput($sformatf("%s_init[%0d]", tag, i),
                    {23'b0, logQ[i].isCmd, logQ[i].data},
                    {23'b0, initExp[i].isCmd, initExp[i].data});
      end
      checkOutput({tag, "_clr_gap"}, 32'(logQ[3].cyc - doneCycQ[2] > CLR_CYC), 32'd1);
    end else begin
      checkOutput({tag, "_init_seen"}, 32'd0, 32'd1);
    end
    checkOutput({tag, "_init_done_early"}, {31'b0, init_done}, 32'd0);
    waitCycles(DONE_LAT + 4);
    checkOutput({tag, "_init_done"}, {31'b0, init_done}, 32'd1);
    checkOutput({tag, "_idle_busy"}, {31'b0, busy}, 32'd0);
    logQ.delete();
    doneCycQ.delete();
  endtask

  initial begin
    int t;
    Rst          = 1'b1;
    buf_we       = 1'b0;
    buf_addr     = '0;
    buf_wdata    = '0;
    refresh_en   = 1'b0;
    spuriousDone = 1'b0;
    modelDone    = 1'b0;
    for (int i = 0; i < 32; i++) bufModel[i] = 8'h20;
    initExp[0] = '{1'b1, 8'h38};
    initExp[1] = '{1'b1, 8'h0C};
    initExp[2] = '{1'b1, 8'h01};
    initExp[3] = '{1'b1, 8'h06};

    // Reset state
    waitCycles(3);
    checkOutput("rst_wr_cmd",    {31'b0, wr_cmd},    32'd0);
    checkOutput("rst_wr_data",   {31'b0, wr_data},   32'd0);
    checkOutput("rst_data",      {24'b0, data},      32'd0);
    checkOutput("rst_init_done", {31'b0, init_done}, 32'd0);
    checkOutput("rst_busy",      {31'b0, busy},      32'd1);

    // Power-up and init; the first buffer write lands during the power-up wait
    Rst    = 1'b0;
    relCyc = cyc;
    logQ.delete();
    doneCycQ.delete();
    applyStimulus(5'd0, 8'h41);
    runInit("boot");

    // Single frame
    applyStimulus(5'd31, 8'h5A);
    buildFrame();
    pulseRefresh();
    waitXfers(FRAME_LEN, FRAME_LEN * 10 + 50);
    compareFrame(0, "frame1");
    waitCycles(DONE_LAT + 5);
    checkOutput("frame1_busy",  {31'b0, busy}, 32'd0);
    checkOutput("frame1_extra", 32'(logQ.size()), 32'(FRAME_LEN));

    // Continuous refresh, dropped at step 10 of the second frame
    logQ.delete();
    doneCycQ.delete();
    applyStimulus(5'd16, 8'h31);
    applyStimulus(5'd7,  8'h48);
    buildFrame();
    @(negedge Clk);
    refresh_en = 1'b1;
    waitXfers(FRAME_LEN + 11, 45 * 10 + 50);
    refresh_en = 1'b0;
    waitXfers(2 * FRAME_LEN, FRAME_LEN * 10 + 50);
    compareFrame(0, "cont_a");
    compareFrame(FRAME_LEN, "cont_b");
    if (logQ.size() >= FRAME_LEN + 1) begin
      checkOutput("restart_gap", 32'(logQ[34].cyc - logQ[33].cyc), 32'(logQ[33].cyc - logQ[32].cyc));
    end else begin
      checkOutput("restart_seen", 32'd0, 32'd1);
    end
    waitCycles(20);
    checkOutput("cont_extra", 32'(logQ.size()), 32'(2 * FRAME_LEN));
    checkOutput("cont_busy",  {31'b0, busy}, 32'd0);

    // Same-cycle write collision on addr 5 (frame step 6)
    logQ.delete();
    doneCycQ.delete();
    buildFrame();
    @(negedge Clk);
    refresh_en = 1'b1;
    waitXfers(6, 100);
    t = 0;
    while (wr_done !== 1'b1 && t < 20) begin
      @(negedge Clk);
      #1;
      t++;
    end
    checkOutput("coll_done_seen", {31'b0, wr_done}, 32'd1);
    @(negedge Clk);
    buf_we    = 1'b1;
    buf_addr  = 5'd5;
    buf_wdata = 8'h55;
    @(negedge Clk);
    buf_we    = 1'b0;
    waitXfers(FRAME_LEN + 1, FRAME_LEN * 10 + 50);
    refresh_en = 1'b0;
    compareFrame(0, "coll_a");
    bufModel[5] = 8'h55;
    buildFrame();
    waitXfers(2 * FRAME_LEN, FRAME_LEN * 10 + 50);
    compareFrame(FRAME_LEN, "coll_b");
    waitCycles(DONE_LAT + 5);

    // Spurious handshake in IDLE
    logQ.delete();
    doneCycQ.delete();
    @(negedge Clk);
    spuriousDone = 1'b1;
    @(negedge Clk);
    spuriousDone = 1'b0;
    waitCycles(10);
    checkOutput("spur_pulses",    32'(logQ.size()), 32'd0);
    checkOutput("spur_busy",      {31'b0, busy},      32'd0);
    checkOutput("spur_init_done", {31'b0, init_done}, 32'd1);

    // Reset while a write is outstanding
    pulseRefresh();
    waitXfers(3, 100);
    waitCycles(1);
    Rst = 1'b1;
    #1;
    checkOutput("mid_rst_wr_cmd",    {31'b0, wr_cmd},    32'd0);
    checkOutput("mid_rst_wr_data",   {31'b0, wr_data},   32'd0);
    checkOutput("mid_rst_data",      {24'b0, data},      32'd0);
    checkOutput("mid_rst_init_done", {31'b0, init_done}, 32'd0);
    checkOutput("mid_rst_busy",      {31'b0, busy},      32'd1);
    waitCycles(2);
    Rst    = 1'b0;
    relCyc = cyc;
    logQ.delete();
    doneCycQ.delete();
    for (int i = 0; i < 32; i++) bufModel[i] = 8'h20;
    runInit("reboot");
    buildFrame();
    pulseRefresh();
    waitXfers(FRAME_LEN, FRAME_LEN * 10 + 50);
    compareFrame(0, "post_rst");
    waitCycles(DONE_LAT + 5);
    checkOutput("post_rst_busy", {31'b0, busy}, 32'd0);

    checkOutput("protocol", 32'(protoErr), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
    $finish;
  end

endmodule

// File: doc/lcd1602_ctrl.md
LCD1602_CTRL -- requirements
Module: lcd1602_ctrl

Interface
REQ-001 Parameter PWRUP_CYC, default 750000, power-up wait in Clk cycles (15 ms at 50 MHz).
REQ-002 Parameter CLR_CYC, default 100000, extra wait after the clear-display command, in Clk cycles (2 ms at 50 MHz).
REQ-003 Port Clk  input  1  single system clock; all logic on rising edge.
REQ-004 Port Rst  input  1  reset, asynchronous, active-high.
REQ-005 Port buf_we  input  1  host character-buffer write strobe.
REQ-006 Port buf_addr  input  5  buffer address; 0-15 = line 1, 16-31 = line 2.
REQ-007 Port buf_wdata  input  8  character code to write.
REQ-008 Port refresh_en  input  1  level; high = refresh the display continuously.
REQ-009 Port init_done  output  1  high once the init sequence completes; sticky until reset.
REQ-010 Port busy  output  1  high in every state except IDLE.
REQ-011 Port wr_cmd  output  1  one-cycle pulse: write the command on data to the LCD driver.
REQ-012 Port wr_data  output  1  one-cycle pulse: write the character on data to the LCD driver.
REQ-013 Port data  output  8  byte for the driver; held stable from the pulse until wr_done.
REQ-014 Port wr_done  input  1  one-cycle driver completion pulse.

Function
REQ-015 States SHALL be PWRUP, INIT_ISSUE, INIT_WAIT, CLR_DLY, IDLE, REF_ISSUE, REF_WAIT.
REQ-016 PWRUP SHALL count PWRUP_CYC cycles, then go to INIT_ISSUE with init step = 0.
REQ-017 Init ROM SHALL be, in order: 0x38, 0x0C, 0x01, 0x06, all issued as commands.
REQ-018 INIT_ISSUE SHALL drive data = ROM[step], pulse wr_cmd for exactly 1 cycle, then enter INIT_WAIT.
REQ-019 INIT_WAIT SHALL hold data until wr_done.
- On wr_done after 0x01: go to CLR_DLY (CLR_CYC cycles), then continue.
- After step 3: set init_done and go to IDLE.
- Otherwise: increment step and return to INIT_ISSUE.
REQ-020 IDLE with refresh_en = 1 SHALL start a frame (frame step = 0) in REF_ISSUE on the next cycle.
REQ-021 Frame steps 0-33 SHALL be:
- Step 0: command 0x80.
- Steps 1-16: data buf[0..15].
- Step 17: command 0xC0.
- Steps 18-33: data buf[16..31].
REQ-022 REF_ISSUE SHALL drive data for the current step, pulse wr_cmd or wr_data for 1 cycle, then enter REF_WAIT.
REQ-023 REF_WAIT SHALL wait for wr_done.
- Step < 33: advance the step and return to REF_ISSUE.
- Step 33 with refresh_en = 1: restart at step 0.
- Step 33 with refresh_en = 0: go to IDLE.
REQ-024 Deasserting refresh_en mid-frame SHALL NOT abort the frame; the frame completes first.
REQ-025 wr_cmd and wr_data SHALL never be high together, and SHALL never pulse while a write is outstanding.
REQ-026 wr_done received outside INIT_WAIT/REF_WAIT SHALL be ignored.
REQ-027 Buffer writes SHALL be accepted every cycle in every state, including PWRUP.
REQ-028 When buf_we targets the address read in the same cycle, the read SHALL return the old value; the new value appears from the next cycle on.
REQ-029 The frame step and init step counters SHALL never exceed 33 and 3 respectively.

Reset
REQ-030 Reset SHALL force: state PWRUP, counters 0, init_done 0, wr_cmd 0, wr_data 0, data 0x00, buffer contents 0x20 (space).
REQ-031 Reset asserted mid-operation SHALL abandon any outstanding write and restart the power-up wait after release.

Structure
REQ-032 Package lcd1602_pkg SHALL hold the state encoding, init ROM command constants, line address constants 0x80/0xC0, and FRAME_LAST = 33.
REQ-033 The 32x8 character buffer SHALL be a sub-module named lcd1602_char_buf (one write port, one asynchronous read port).
REQ-034 lcd1602_ctrl SHALL connect directly to the existing lcd1602_driver command/data handshake.

Verification (PWRUP_CYC = 20, CLR_CYC = 10, driver model returning wr_done 5 cycles after each pulse)
REQ-035 Check power-up and init:
- Stimulus: release reset.
- Response: no pulse for 20 cycles; then wr_cmd with 0x38, 0x0C, 0x01, 0x06.
- Response: at least 10 idle cycles between wr_done(0x01) and the 0x06 pulse; init_done rises after wr_done(0x06).
REQ-036 Check a single frame:
- Stimulus: write 'A' (0x41) at addr 0 and 'Z' (0x5A) at addr 31; pulse refresh_en high for one frame.
- Response: 0x80 cmd, 0x41, 15x 0x20, 0xC0 cmd, 15x 0x20, 0x5A; then IDLE with busy = 0.
REQ-037 Check continuous refresh:
- Stimulus: hold refresh_en high.
- Response: step 33 completes, then a 0x80 cmd is issued immediately.
- Stimulus: drop refresh_en at step 10.
- Response: the frame finishes at step 33, then IDLE.
REQ-038 Check a same-cycle write collision:
- Stimulus: buf_we at addr 5 with 0x55 in the cycle REF_ISSUE reads addr 5.
- Response: old 0x20 is sent; the next frame sends 0x55.
REQ-039 Check reset mid-write:
- Stimulus: assert Rst while in REF_WAIT.
- Response: outputs reset immediately, buffer reads 0x20, the sequence restarts from PWRUP.
REQ-040 Check a spurious handshake:
- Stimulus: inject wr_done while in IDLE.
- Response: no state change, no pulse.
